// File: rtl/wave_mixer.sv
// wave_mixer: per-channel ready/valid capture, gain, sequential accumulation and saturation to one output sample per frame
module wave_mixer #(
    parameter int width_p      = 16,
    parameter int channels_p   = 4,
    parameter int gain_width_p = 4,
    parameter int gain_frac_p  = 3
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [channels_p-1:0]              enable_i,
    input  logic [channels_p*gain_width_p-1:0] gain_i,
    input  logic [channels_p*width_p-1:0]      data_i,
    input  logic [channels_p-1:0]              valid_i,
    output logic [channels_p-1:0]              ready_o,
    output logic [width_p-1:0]                 data_o,
    output logic                               clip_o,
    output logic                               valid_o,
    input  logic                               ready_i
);
    localparam int aw_c = width_p + gain_width_p + $clog2(channels_p) + 1;
    localparam int iw_c = channels_p > 1 ? $clog2(channels_p) : 1;
    localparam logic [1:0] st_collect = 2'd0, st_accum = 2'd1, st_sat = 2'd2, st_out = 2'd3;
    localparam logic signed [aw_c-1:0] sat_hi_c = aw_c'((64'sd1 <<< (width_p - 1)) - 64'sd1);
    localparam logic signed [aw_c-1:0] sat_lo_c = -sat_hi_c - aw_c'(1);
    logic [1:0]                        state;
    logic                              latched;
    logic [channels_p-1:0]             en_q, cap, take;
    logic [channels_p*gain_width_p-1:0] gain_q;
    logic signed [width_p-1:0]         samp_q [channels_p];
    logic signed [aw_c-1:0]            acc, term;
    logic signed [width_p+gain_width_p:0] prod;
    logic [iw_c-1:0]                   idx;
    assign ready_o = (state == st_collect && latched) ? en_q & ~cap : '0;
    assign take    = ready_o & valid_i;
    assign prod    = samp_q[idx] * $signed({1'b0, gain_q[idx*gain_width_p +: gain_width_p]});
    assign term    = aw_c'(prod >>> gain_frac_p);
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= st_collect;
            latched <= 1'b0;
            en_q    <= '0;
            gain_q  <= '0;
            cap     <= '0;
            acc     <= '0;
            idx     <= '0;
            data_o  <= '0;
            clip_o  <= 1'b0;
            valid_o <= 1'b0;
            for (int c = 0; c < channels_p; c++) samp_q[c] <= '0;
        end else begin
            case (state)
                st_collect: begin
                    if (!latched) begin
                        en_q    <= enable_i;
                        gain_q  <= gain_i;
                        latched <= 1'b1;
                        if (enable_i == '0) begin
                            state <= st_accum;
                            acc   <= '0;
                            idx   <= '0;
                        end
                    end else begin
                        for (int c = 0; c < channels_p; c++)
                            if (take[c]) samp_q[c] <= data_i[c*width_p +: width_p];
                        cap <= cap | take;
                        // the capture edge itself may complete the frame
                        if ((en_q & ~(cap | take)) == '0) begin
                            state <= st_accum;
                            acc   <= '0;
                            idx   <= '0;
                        end
                    end
                end
                st_accum: begin
                    if (en_q[idx]) acc <= acc + term;
                    idx <= idx + 1'b1;
                    if (idx == iw_c'(channels_p - 1)) state <= st_sat;
                end
                st_sat: begin
                    data_o <= acc > sat_hi_c ? {1'b0, {(width_p-1){1'b1}}} :
                              acc < sat_lo_c ? {1'b1, {(width_p-1){1'b0}}} : acc[width_p-1:0];
                    clip_o <= acc > sat_hi_c || acc < sat_lo_c;
                    state  <= st_out;
                end
                default: begin
                    if (!valid_o) valid_o <= 1'b1;
                    else if (ready_i) begin
                        valid_o <= 1'b0;
                        clip_o  <= 1'b0;
                        cap     <= '0;
                        latched <= 1'b0;
                        state   <= st_collect;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wave_mixer.sv
// tb_wave_mixer: directed checks of capture, gain, saturation, backpressure and reset for wave_mixer
module tb_wave_mixer;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [3:0]  enable_i = '0;
    logic [15:0] gain_i = '0;
    logic [63:0] data_i = '0;
    logic [3:0]  valid_i = '0;
    logic [3:0]  ready_o;
    logic [15:0] data_o;
    logic        clip_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    int checks = 0;
    int errors = 0;
    wave_mixer dut (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .gain_i(gain_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o),
        .clip_o(clip_o), .valid_o(valid_o), .ready_i(ready_i)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wait_valid(input string tag, input logic [3:0] en);
        logic [3:0] bad = '0;
        for (int i = 0; i < 40 && !valid_o; i++) begin
            bad |= ready_o & ~en;
            step();
        end
        chk({tag, "_timeout"}, valid_o, 1);
        chk({tag, "_ready_dis"}, bad, 0);
    endtask
    task automatic frame(input string tag, input logic [3:0] en, input logic [15:0] g,
                         input logic [63:0] d, input logic [15:0] exp_d, input logic exp_c);
        enable_i = en; gain_i = g; data_i = d; valid_i = 4'hf; ready_i = 1'b0;
        wait_valid(tag, en);
        chk({tag, "_data"}, data_o, exp_d);
        chk({tag, "_clip"}, clip_o, exp_c);
        valid_i = 4'h0; ready_i = 1'b1;
        step();
        chk({tag, "_valid_drop"}, valid_o, 0);
        chk({tag, "_data_hold"}, data_o, exp_d);
        ready_i = 1'b0;
    endtask
    initial begin
        step(); step();
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_clip", clip_o, 0);
        reset_i = 1'b0;
        frame("unity", 4'hf, 16'h8888, {16'd400, 16'd300, 16'd200, 16'd100}, 16'd1000, 1'b0);
        // reset asserted while the accumulator is running
        enable_i = 4'hf; gain_i = 16'h8888; data_i = {16'd400, 16'd300, 16'd200, 16'd100}; valid_i = 4'hf;
        step(); step(); step();
        valid_i = 4'h0;
        #2 reset_i = 1'b1;
        #1;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_ready", ready_o, 0);
        chk("midrst_data", data_o, 0);
        step();
        reset_i = 1'b0;
        frame("fresh", 4'hf, 16'h8888, {16'd400, 16'd300, 16'd200, 16'd100}, 16'd1000, 1'b0);
        frame("sat_pos", 4'hf, 16'hffff, {4{16'h7000}}, 16'h7fff, 1'b1);
        frame("sat_neg", 4'hf, 16'hffff, {4{16'h9000}}, 16'h8000, 1'b1);
        frame("max_exact", 4'h1, 16'h0008, {48'd0, 16'h7fff}, 16'h7fff, 1'b0);
        frame("min_exact", 4'h1, 16'h0008, {48'd0, 16'h8000}, 16'h8000, 1'b0);
        frame("gain_en", 4'b0101, 16'hf4f8, {16'h7fff, -16'sd1000, 16'h7fff, 16'd1000}, 16'd500, 1'b0);
        // out-of-order single-cycle captures; enable/gain changes after the latch are ignored
        enable_i = 4'hf; gain_i = 16'h8888; data_i = {16'd4, 16'd3, 16'd2, 16'd1}; valid_i = 4'h0;
        step();
        chk("ooo_ready_all", ready_o, 4'hf);
        enable_i = 4'h0; gain_i = 16'h0;
        valid_i = 4'b1000; step(); chk("ooo_ready_3", ready_o, 4'b0111);
        valid_i = 4'b0010; step(); chk("ooo_ready_1", ready_o, 4'b0101);
        valid_i = 4'b0001; step(); chk("ooo_ready_0", ready_o, 4'b0100);
        valid_i = 4'b0100; step(); chk("ooo_ready_2", ready_o, 4'b0000);
        valid_i = 4'h0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("ooo_lat%0d", i), valid_o, 0);
        end
        step();
        chk("ooo_lat6", valid_o, 1);
        chk("ooo_data", data_o, 16'd10);
        chk("ooo_clip", clip_o, 0);
        ready_i = 1'b1; step(); ready_i = 1'b0;
        chk("ooo_drop", valid_o, 0);
        // backpressure with enable_i toggling during OUT
        enable_i = 4'hf; gain_i = 16'h8888; data_i = {16'd32, 16'd24, 16'd16, 16'd8}; valid_i = 4'hf;
        wait_valid("bp", 4'hf);
        valid_i = 4'h0;
        for (int i = 0; i < 20; i++) begin
            enable_i = i[0] ? 4'h0 : 4'hf;
            step();
            chk($sformatf("bp_valid%0d", i), valid_o, 1);
            chk($sformatf("bp_data%0d", i), data_o, 16'd80);
            chk($sformatf("bp_ready%0d", i), ready_o, 0);
        end
        enable_i = 4'b0001;
        ready_i = 1'b1; step(); ready_i = 1'b0;
        chk("bp_drop", valid_o, 0);
        frame("after_bp", 4'b0001, 16'h8888, {16'd32, 16'd24, 16'd16, 16'd7}, 16'd7, 1'b0);
        frame("all_off", 4'h0, 16'h8888, {16'd32, 16'd24, 16'd16, 16'd7}, 16'd0, 1'b0);
        frame("floor", 4'h1, 16'h0004, {48'd0, 16'hffff}, 16'hffff, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
